// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: round count, round constants, FSM encoding and byte-order helpers.
package aes_128_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    // Rcon for expansion step r (0-based); only the low byte is non-zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // BYTE_SWAP: the core keeps byte 0 in bits [7:0], FIPS-197 text lists byte 0 first (MSB).
    // Converting between the two is a plain 16-byte reversal.
    function automatic logic [127:0] byte_swap128(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = v[8*(15-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_128_sbox.sv
// Combinational AES forward S-box, 256-entry lookup; shared with the cipher core.
module aes_128_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout_c
);

    // Entry 0 sits in the top byte, so entry a lives at bit offset 8*(255-a) = {~a, 3'b000}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout_c = SBOX_TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_128_key_feeder.sv
// Expands a loaded AES-128 key into round keys 1..10 and serves them to the core one per key_ready.
module aes_128_key_feeder #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         in_en,
    input  logic         key_ready,
    input  logic         out_en,
    output logic [127:0] key_round,
    output logic         key_valid,
    output logic         busy,
    output logic         key_err
);
    import aes_128_pkg::*;

    localparam int unsigned IW = 4;

    state_t          state;
    logic [127:0]    ck_reg;
    logic [127:0]    w_reg;
    logic [127:0]    w_next;
    logic [127:0]    rk [NR];
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rcnt;
    logic [31:0]     rot_w;
    logic [31:0]     sub_w;
    logic [31:0]     t_w;
    logic [31:0]     w0n, w1n, w2n, w3n;

    // SubWord(RotWord(w3)) with byte 0 in the low bits.
    assign rot_w = {w_reg[103:96], w_reg[127:104]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_128_sbox u_sbox (
            .din    (rot_w[8*g +: 8]),
            .dout_c (sub_w[8*g +: 8])
        );
    end

    always_comb begin
        t_w    = sub_w ^ {24'h0, rcon_of(rcnt)};
        w0n    = w_reg[31:0]   ^ t_w;
        w1n    = w_reg[63:32]  ^ w0n;
        w2n    = w_reg[95:64]  ^ w1n;
        w3n    = w_reg[127:96] ^ w2n;
        w_next = {w3n, w2n, w1n, w0n};
    end

    // Round-key storage carries no reset; contents are meaningless until key_valid.
    always_ff @(posedge clk) begin
        if (state == ST_EXPAND && !key_load) begin
            rk[rcnt] <= w_next;
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state     <= ST_IDLE;
            ck_reg    <= '0;
            w_reg     <= '0;
            idx       <= '0;
            rcnt      <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            if (out_en) begin
                key_round <= ck_reg;
                idx       <= '0;
            end else if (in_en && key_ready) begin
                key_round <= rk[0];
                idx       <= IW'(1);
            end else if (in_en) begin
                idx <= '0;
            end else if (key_ready) begin
                if (key_valid && idx < IW'(NR)) begin
                    key_round <= rk[idx];
                    idx       <= idx + IW'(1);
                end else begin
                    key_err <= 1'b1;
                end
            end

            case (state)
                ST_EXPAND: begin
                    w_reg <= w_next;
                    rcnt  <= rcnt + IW'(1);
                    if (rcnt == IW'(NR - 1)) begin
                        state     <= ST_READY;
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        key_round <= ck_reg;
                    end
                end
                default: ;
            endcase

            // A load overrides everything else on this edge and restarts expansion.
            if (key_load) begin
                state     <= ST_EXPAND;
                ck_reg    <= key_in;
                w_reg     <= key_in;
                rcnt      <= '0;
                idx       <= '0;
                key_valid <= 1'b0;
                key_err   <= 1'b0;
                busy      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_128_key_feeder.sv
// Self-checking bench for aes_128_key_feeder against a byte-level FIPS-197 key schedule model.
module tb_aes_128_key_feeder;

    logic         clk;
    logic         kill;
    logic [127:0] key_in;
    logic         key_load;
    logic         in_en;
    logic         key_ready;
    logic         out_en;
    logic [127:0] key_round;
    logic         key_valid;
    logic         busy;
    logic         key_err;

    int n_checks;
    int n_fail;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [10];

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk0;
        logic [127:0] rk9;
        int           gap;
    } vec_t;

    vec_t vecs [3];

    aes_128_key_feeder #(.NR(10)) dut (
        .clk       (clk),
        .kill      (kill),
        .key_in    (key_in),
        .key_load  (key_load),
        .in_en     (in_en),
        .key_ready (key_ready),
        .out_en    (out_en),
        .key_round (key_round),
        .key_valid (key_valid),
        .busy      (busy),
        .key_err   (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (x != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // FIPS-197 key schedule over 44 byte-words; results packed back with byte 0 in bits [7:0].
    task automatic expand_ref(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [7:0] tmp;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = key[8*(4*i+j) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
                t[0] = t[0] ^ rc;
                rc = xtime(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int r = 0; r < 10; r++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    exp_rk[r][8*(4*i+j) +: 8] = w[4*(r+1)+i][j];
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a key and wait (bounded) for key_valid, counting busy cycles.
    task automatic load_and_wait(input logic [127:0] k);
        int busy_cnt;
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 20 && !key_valid; c++) begin
            if (busy) busy_cnt++;
            step();
        end
        check("busy_cycles", 128'(busy_cnt), 128'd10);
        check("valid_after_expand", 128'(key_valid), 128'd1);
        check("busy_low_when_valid", 128'(busy), 128'd0);
        check("round_is_cipher_key", key_round, k);
    endtask

    task automatic serve_block(input logic [127:0] k, input int gap, input bit rand_gap);
        int g;
        in_en = 1'b1;
        repeat (3) step();
        in_en = 1'b0;
        for (int r = 0; r < 10; r++) begin
            g = rand_gap ? int'($urandom_range(1, 4)) : gap;
            repeat (g - 1) step();
            key_ready = 1'b1;
            step();
            key_ready = 1'b0;
            check($sformatf("round_key_%0d", r), key_round, exp_rk[r]);
        end
        out_en = 1'b1;
        step();
        out_en = 1'b0;
        check("out_en_returns_key", key_round, k);
        check("no_err_in_block", 128'(key_err), 128'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        kill      = 1'b1;
        key_in    = '0;
        key_load  = 1'b0;
        in_en     = 1'b0;
        key_ready = 1'b0;
        out_en    = 1'b0;

        for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

        vecs[0] = '{key: 128'h0f0e0d0c0b0a09080706050403020100,
                    rk0: 128'hfe76abd6f178a6dafa72afd2fd74aad6,
                    rk9: 128'hc5302b4d8ba707f3174a94e37f1d1113, gap: 4};
        vecs[1] = '{key: 128'h3c4fcf098815f7aba6d2ae2816157e2b,
                    rk0: 128'h05766c2a3939a323b12c548817fefaa0,
                    rk9: 128'ha60c63b6c80c3fe18925eec9a8f914d0, gap: 1};
        vecs[2] = '{key: 128'h0f0e0d0c0b0a09080706050403020100,
                    rk0: 128'hfe76abd6f178a6dafa72afd2fd74aad6,
                    rk9: 128'hc5302b4d8ba707f3174a94e37f1d1113, gap: 2};

        #12;
        check("rst_key_round", key_round, 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_err", 128'(key_err), 128'd0);
        @(negedge clk);
        kill = 1'b0;
        step();

        // Known-answer vectors, each served twice back to back.
        foreach (vecs[v]) begin
            expand_ref(vecs[v].key);
            check("model_rk0", exp_rk[0], vecs[v].rk0);
            check("model_rk9", exp_rk[9], vecs[v].rk9);
            load_and_wait(vecs[v].key);
            serve_block(vecs[v].key, vecs[v].gap, 1'b0);
            serve_block(vecs[v].key, vecs[v].gap, 1'b0);
        end

        // Random keys with random request spacing.
        for (int n = 0; n < 5; n++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            expand_ref(k);
            load_and_wait(k);
            serve_block(k, 1, 1'b1);
        end

        // key_ready during expansion sets a sticky error; a new load clears it.
        expand_ref(vecs[0].key);
        key_in = vecs[0].key; key_load = 1'b1; step(); key_load = 1'b0;
        step(); step();
        key_ready = 1'b1; step(); key_ready = 1'b0;
        check("err_ready_in_expand", 128'(key_err), 128'd1);
        repeat (12) step();
        check("err_sticky", 128'(key_err), 128'd1);
        check("valid_after_err", 128'(key_valid), 128'd1);
        load_and_wait(vecs[0].key);
        check("err_cleared_by_load", 128'(key_err), 128'd0);

        // Joint in_en+key_ready gives rk[0]; consecutive requests; 11th request errors and holds.
        in_en = 1'b1; key_ready = 1'b1; step(); in_en = 1'b0;
        check("joint_in_en_ready", key_round, exp_rk[0]);
        for (int r = 1; r < 10; r++) begin
            step();
            check($sformatf("b2b_round_%0d", r), key_round, exp_rk[r]);
        end
        check("no_err_at_ten", 128'(key_err), 128'd0);
        step();
        key_ready = 1'b0;
        check("eleventh_holds", key_round, exp_rk[9]);
        check("eleventh_err", 128'(key_err), 128'd1);

        // out_en outranks key_ready.
        out_en = 1'b1; key_ready = 1'b1; step(); out_en = 1'b0; key_ready = 1'b0;
        check("out_en_priority", key_round, vecs[0].key);

        // Asynchronous kill mid-expansion, then a clean reload.
        key_in = vecs[1].key; key_load = 1'b1; step(); key_load = 1'b0;
        key_ready = 1'b1; step(); key_ready = 1'b0;
        repeat (4) step();
        check("busy_before_kill", 128'(busy), 128'd1);
        #2 kill = 1'b1;
        #1;
        check("kill_key_round", key_round, 128'd0);
        check("kill_busy", 128'(busy), 128'd0);
        check("kill_valid", 128'(key_valid), 128'd0);
        check("kill_err", 128'(key_err), 128'd0);
        @(negedge clk);
        kill = 1'b0;
        expand_ref(vecs[1].key);
        load_and_wait(vecs[1].key);
        serve_block(vecs[1].key, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
